// File: rtl/tern_popcount_neuron_seq.sv
// Streaming ternary neuron: accumulates popcount(pos) - popcount(neg)
// over WIDTH-bit beats, saturates, and applies a dual threshold.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   approx_en           LSB truncation of per-beat counts (first beat)
//   thr_hi, thr_lo      signed thresholds (first beat)
//   in_valid/in_ready   beat handshake; in_pos, in_neg, in_last
//   out_valid/out_ready result handshake
//   out_sum, out_act    signed sum, ternary activation (01 +1, 11 -1)
//   out_sat, out_trunc  sticky saturation, forced close at MAX_BEATS
module tern_popcount_neuron_seq #(
    parameter int WIDTH     = 31,
    parameter int ACC_W     = 12,
    parameter int TRUNC     = 2,
    parameter int MAX_BEATS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    approx_en,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [WIDTH-1:0] in_pos,
    input  logic        [WIDTH-1:0] in_neg,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic              [1:0] out_act,
    output logic                    out_sat,
    output logic                    out_trunc
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(MAX_BEATS + 1);
    // Wide enough that acc + d never wraps before the clamp.
    localparam int SW = (CW + 1 > ACC_W) ? CW + 2 : ACC_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] TMASK = {CW{1'b1}} << TRUNC;
    localparam logic signed [SW-1:0] MAXV =
        {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
        {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic              [1:0] r_state;
    logic           [BW-1:0] r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_thi;
    logic signed [ACC_W-1:0] r_tlo;
    logic                    r_apx;
    logic                    r_sat;
    logic                    r_trunc;

    logic           [CW-1:0] w_p;
    logic           [CW-1:0] w_n;
    logic           [CW-1:0] w_pm;
    logic           [CW-1:0] w_nm;
    logic                    w_apx;
    logic                    w_first;
    logic                    w_acc_en;
    logic signed    [SW-1:0] w_d;
    logic signed    [SW-1:0] w_base;
    logic signed    [SW-1:0] w_sum;
    logic                    w_hi;
    logic                    w_lo;
    logic signed [ACC_W-1:0] w_acc_n;
    logic           [BW-1:0] w_cnt_n;
    logic                    w_lim;
    logic                    w_close;

    always_comb begin
        w_p = '0;
        w_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_p = w_p + CW'(in_pos[i]);
            w_n = w_n + CW'(in_neg[i]);
        end
    end

    assign in_ready  = !rst && (r_state != S_DONE);
    assign w_first   = (r_state == S_IDLE);
    assign w_acc_en  = in_valid && in_ready;

    // The first beat uses the live approx_en, later beats the latched copy.
    assign w_apx  = w_first ? approx_en : r_apx;
    assign w_pm   = w_apx ? (w_p & TMASK) : w_p;
    assign w_nm   = w_apx ? (w_n & TMASK) : w_n;
    assign w_d    = SW'($signed({1'b0, w_pm})) - SW'($signed({1'b0, w_nm}));
    assign w_base = w_first ? '0 : SW'(r_acc);
    assign w_sum  = w_base + w_d;
    assign w_hi   = (w_sum > MAXV);
    assign w_lo   = (w_sum < MINV);

    always_comb begin
        w_acc_n = w_sum[ACC_W-1:0];
        if (w_hi) w_acc_n = MAXV[ACC_W-1:0];
        else if (w_lo) w_acc_n = MINV[ACC_W-1:0];
    end

    assign w_cnt_n = w_first ? BW'(1) : r_cnt + BW'(1);
    assign w_lim   = (w_cnt_n == BW'(MAX_BEATS));
    assign w_close = in_last || w_lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_thi   <= '0;
            r_tlo   <= '0;
            r_apx   <= 1'b0;
            r_sat   <= 1'b0;
            r_trunc <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_acc_en) begin
                        if (w_first) begin
                            r_apx <= approx_en;
                            r_thi <= thr_hi;
                            r_tlo <= thr_lo;
                        end
                        r_acc   <= w_acc_n;
                        r_sat   <= (!w_first && r_sat) || w_hi || w_lo;
                        r_cnt   <= w_cnt_n;
                        r_trunc <= w_lim && !in_last;
                        r_state <= w_close ? S_DONE : S_ACC;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
                        r_trunc <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_acc;
    assign out_sat   = r_sat;
    assign out_trunc = r_trunc;

    // Activation is only meaningful with a result; +1 wins on overlap.
    always_comb begin
        out_act = 2'b00;
        if (out_valid) begin
            if (r_acc >= r_thi) out_act = 2'b01;
            else if (r_acc <= r_tlo) out_act = 2'b11;
        end
    end

endmodule

// File: tb/tb_tern_popcount_neuron_seq.sv
// Directed bench for tern_popcount_neuron_seq (ACC_W=6, MAX_BEATS=4 so
// saturation and forced close are reachable with short vectors).
module tb_tern_popcount_neuron_seq;

    localparam int W  = 31;
    localparam int AW = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 approx_en = 1'b0;
    logic signed [AW-1:0] thr_hi = 6'sd10;
    logic signed [AW-1:0] thr_lo = -6'sd10;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic        [W-1:0]  in_pos = '0;
    logic        [W-1:0]  in_neg = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] out_sum;
    logic           [1:0] out_act;
    logic                 out_sat;
    logic                 out_trunc;

    int n_chk  = 0;
    int n_pass = 0;

    tern_popcount_neuron_seq #(
        .WIDTH(W), .ACC_W(AW), .TRUNC(2), .MAX_BEATS(4)
    ) dut (
        .clk(clk), .rst(rst), .approx_en(approx_en),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act),
        .out_sat(out_sat), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] p, input logic [W-1:0] n,
                        input logic last, input logic apx);
        bit done = 0;
        in_valid  = 1'b1;
        in_pos    = p;
        in_neg    = n;
        in_last   = last;
        approx_en = apx;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        if (!done) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic res(input string tag, input logic signed [AW-1:0] sum,
                       input logic [1:0] act, input logic sat,
                       input logic trn);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_sum"}, 32'(unsigned'(out_sum)), 32'(unsigned'(sum)));
        chk({tag, "_act"}, 32'(out_act), 32'(act));
        chk({tag, "_sat"}, 32'(out_sat), 32'(sat));
        chk({tag, "_trunc"}, 32'(out_trunc), 32'(trn));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consumed_valid", 32'(out_valid), 0);
        chk("consumed_ready", 32'(in_ready), 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(unsigned'(out_sum)), 0);
        chk("rst_act", 32'(out_act), 0);
        chk("rst_sat", 32'(out_sat), 0);
        chk("rst_trunc", 32'(out_trunc), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(in_ready), 1);

        // 1: single full beat
        beat(31'h7FFFFFFF, '0, 1, 0);
        res("t1", 6'sd31, 2'b01, 0, 0);
        consume();

        // 2: three beats 5/9, 3/3, 0/7
        beat(31'h1F, 31'h1FF, 0, 0);
        chk("t2_mid_valid", 32'(out_valid), 0);
        beat(31'h7, 31'h7, 0, 0);
        beat('0, 31'h7F, 1, 0);
        res("t2a", -6'sd11, 2'b11, 0, 0);
        consume();
        beat(31'hFFFF, 31'hFFFF, 1, 0);
        res("t2b", 6'sd0, 2'b00, 0, 0);
        consume();

        // 3: approximation p=7 n=2
        beat(31'h7F, 31'h3, 1, 1);
        res("t3_apx", 6'sd4, 2'b00, 0, 0);
        consume();
        beat(31'h7F, 31'h3, 1, 0);
        res("t3_exact", 6'sd5, 2'b00, 0, 0);
        consume();
        beat(31'h7F, 31'h3, 0, 1);
        beat(31'h7F, 31'h3, 1, 0);
        res("t3_tog_on", 6'sd8, 2'b00, 0, 0);
        consume();
        beat(31'h7F, 31'h3, 0, 0);
        beat(31'h7F, 31'h3, 1, 1);
        res("t3_tog_off", 6'sd10, 2'b01, 0, 0);
        consume();
        beat('0, 31'h3FF, 1, 0);
        res("t3_lo_edge", -6'sd10, 2'b11, 0, 0);
        consume();

        // 4: saturation at +31
        beat(31'h7FFFFFFF, '0, 0, 0);
        beat(31'h7FFFFFFF, '0, 0, 0);
        beat(31'h7FFFFFFF, '0, 1, 0);
        res("t4_sat", 6'sd31, 2'b01, 1, 0);
        consume();
        beat(31'h1, '0, 1, 0);
        res("t4_clear", 6'sd1, 2'b00, 0, 0);
        consume();
        for (int i = 0; i < 3; i++) beat('0, 31'h7FFFFFFF, i == 2, 0);
        res("t4_neg_sat", -6'sd32, 2'b11, 1, 0);
        consume();

        // 5: forced close after 4 beats
        for (int i = 0; i < 4; i++) beat(31'h1, '0, 0, 0);
        res("t5_v1", 6'sd4, 2'b00, 0, 1);
        in_valid = 1'b1;
        in_pos   = 31'h1;
        in_last  = 1'b1;
        #2;
        chk("t5_stall_ready", 32'(in_ready), 0);
        consume();
        beat(31'h1, '0, 1, 0);
        res("t5_v2", 6'sd1, 2'b00, 0, 0);
        consume();

        // 6: backpressure then reset mid-vector
        beat(31'h7, '0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            res("t6_hold", 6'sd3, 2'b00, 0, 0);
            chk("t6_hold_ready", 32'(in_ready), 0);
            tick();
        end
        consume();
        beat(31'hFF, '0, 0, 0);
        beat(31'hFF, '0, 0, 0);
        rst = 1'b1;
        tick();
        chk("t6_rst_ready", 32'(in_ready), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_sum", 32'(unsigned'(out_sum)), 0);
        chk("t6_rst_act", 32'(out_act), 0);
        chk("t6_rst_sat", 32'(out_sat), 0);
        chk("t6_rst_trunc", 32'(out_trunc), 0);
        rst = 1'b0;
        tick();
        chk("t6_ready_back", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_valid", 32'(out_valid), 0);
            tick();
        end
        beat(31'h3, '0, 1, 0);
        res("t6_fresh", 6'sd2, 2'b00, 0, 0);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tern_popcount_neuron_seq.md
Name: tern_popcount_neuron_seq

Overview:
- Sequential, parametrised successor to the fixed 31-input combinational popcount used in our ternary printed neurons.
- Consumes an activation vector of arbitrary length as a stream of WIDTH-bit beats, each beat carrying a positive-weight match mask and a negative-weight match mask.
- Accumulates the signed difference popcount(pos) - popcount(neg) over all beats, then applies a dual threshold to emit a ternary activation.
- Has a run-time approximation mode (LSB truncation of per-beat counts) in place of a hard-wired approximate netlist. Sits between the sensor front-end buffer and the next neuron layer.

Parameters:
WIDTH, 31, bits per beat (1..63)
ACC_W, 12, signed accumulator and threshold width (two's complement)
TRUNC, 2, LSBs of each per-beat count forced to 0 when approximation is enabled (0..clog2(WIDTH+1)-1)
MAX_BEATS, 64, beat limit per vector; a vector is force-closed when the limit is reached

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
approx_en  in  1  approximation mode; sampled on the first beat of a vector
thr_hi  in  ACC_W  signed upper threshold; sampled on the first beat
thr_lo  in  ACC_W  signed lower threshold; sampled on the first beat
in_valid  in  1  beat valid
in_ready  out  1  beat accept
in_pos  in  WIDTH  positive-weight match bits
in_neg  in  WIDTH  negative-weight match bits
in_last  in  1  final beat of the vector
out_valid  out  1  result valid
out_ready  in  1  result accept
out_sum  out  ACC_W  signed accumulated sum
out_act  out  2  ternary activation: 01 = +1, 11 = -1, 00 = 0
out_sat  out  1  accumulator saturated at some point during the vector
out_trunc  out  1  vector force-closed at MAX_BEATS without in_last

Behaviour:
- Reset: synchronous on clk when rst = 1; overrides all other inputs in that cycle.
- Reset values: in_ready = 0, out_valid = 0, out_sum = 0, out_act = 00, out_sat = 0, out_trunc = 0. FSM goes to IDLE and the beat counter to 0.
- in_ready rises in the first cycle after rst deasserts.
- Reset mid-vector discards the partial accumulation; no output is produced for that vector.
- Handshake: a beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- in_ready = 1 in IDLE and ACC, 0 in DONE.
- Beat accept = in_valid & in_ready, in any of the states below.
- Per-beat arithmetic:
  - p = popcount(in_pos), n = popcount(in_neg), each clog2(WIDTH+1) bits and exact.
  - If the latched approx_en = 1, clear the low TRUNC bits of p and of n before use.
  - d = p - n, sign-extended to ACC_W+1 bits.
  - acc_next = acc + d, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets the sticky sat flag.
- FSM:
  - IDLE: on beat accept, latch approx_en, thr_hi and thr_lo (this beat uses the new approx_en); acc = d; sat = saturation of d alone; cnt = 1. Go to DONE if in_last or MAX_BEATS = 1, otherwise ACC.
  - ACC: on beat accept, acc = sat(acc + d); cnt += 1. Go to DONE if in_last or the post-increment cnt = MAX_BEATS. Set trunc = 1 when the limit closes the vector and in_last = 0.
  - DONE: out_valid = 1. out_sum = acc. out_act = 01 if acc >= thr_hi; else 11 if acc <= thr_lo; else 00. If thr_lo >= thr_hi and both conditions hold, +1 wins. out_sat = sat, out_trunc = trunc.
  - On consume, go to IDLE; cnt, sat and trunc clear and out_valid falls in the next cycle.
- Latency: out_valid is registered and rises in the cycle after the closing beat is accepted. A vector of B beats, streamed back-to-back, finishes B+1 cycles after its first beat.
- Throughput: one dead cycle per vector (DONE → IDLE). A beat presented during DONE stalls until in_ready returns.
- Outputs hold stable while out_valid = 1 and out_ready = 0.
- Beats arriving after a forced close belong to the next vector.
- in_pos and in_neg bits that are both 1 at the same index are counted in both p and n (net 0). This is not an error.

Test Plan:
1. Reset, 1 beat, pos = 0x7FFFFFFF, neg = 0, last = 1, approx off, thr_hi = 10, thr_lo = -10 → out_valid one cycle later; sum = 31, act = 01, sat = 0, trunc = 0.
2. 3 beats (pos/neg popcounts 5/9, 3/3, 0/7), last on beat 3, thr_hi = 10, thr_lo = -10 → sum = -11, act = 11; second vector pos = neg = 0x0000FFFF → sum = 0, act = 00.
3. Approx on, TRUNC = 2, 1 beat with p = 7, n = 2 → d = 4 - 0 = 4, sum = 4. The same beat with approx off gives sum = 5. Toggling approx_en mid-vector has no effect.
4. Saturation, ACC_W = 6: 3 beats of pos = all ones (31 each) → sum = 31, sat = 1, act per thresholds; next vector sat = 0.
5. Limit, MAX_BEATS = 4: 5 beats, no last, p = 1 each → vector 1 sum = 4, trunc = 1; beat 5 forms vector 2 with sum = 1 on its last.
6. Backpressure plus reset: hold out_ready = 0 for 5 cycles → outputs stable and in_ready = 0; then rst mid-ACC of the next vector → all outputs return to reset values and no spurious out_valid appears.
